// File: rtl/udp_panel_dispatch_if.sv
// Stream and write-bus interfaces for udp_panel_dispatch: the liteeth UDP
// source stream it consumes and the shared ledpanel write bus it drives.

interface udp_source_if;
   logic        valid;
   logic        last;
   logic        ready;
   logic [15:0] dst_port;
   logic [31:0] data;

   modport master (output valid, last, dst_port, data, input ready);
   modport slave  (input valid, last, dst_port, data, output ready);
endinterface

interface panel_ctrl_if #(
   parameter int NUM_PANELS = 5,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 24
);
   logic                  ready;
   logic [NUM_PANELS-1:0] en;
   logic [3:0]            wr;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdat;

   modport master (output en, wr, addr, wdat, input ready);
   modport slave  (input en, wr, addr, wdat, output ready);
endinterface

// File: rtl/udp_panel_dispatch.sv
// Parses one header word per UDP packet and dispatches pixel writes, buffer
// swaps and LED toggles to NUM_PANELS ledpanels; malformed packets are drained.

module udp_panel_dispatch #(
   parameter int          NUM_PANELS = 5,
   parameter int          ADDR_W     = 16,
   parameter int          DATA_W     = 24,
   parameter logic [15:0] UDP_PORT   = 16'h1a00,
   parameter int          CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  resetn,
   udp_source_if.slave           udp_source,
   panel_ctrl_if.master          ctrl,
   output logic [NUM_PANELS-1:0] swap,
   output logic                  led_reg,
   output logic [CNT_W-1:0]      pkt_count,
   output logic [CNT_W-1:0]      drop_count
);

   typedef enum logic [1:0] {S_HDR, S_WRITE, S_DRAIN} state_t;

   localparam logic [3:0] CMD_WRITE_PIX  = 4'd1;
   localparam logic [3:0] CMD_SWAP       = 4'd2;
   localparam logic [3:0] CMD_LED_TOGGLE = 4'd3;
   localparam logic [7:0] IDX_BROADCAST  = 8'hFF;

   state_t                state;
   logic [NUM_PANELS-1:0] en_q;
   logic [NUM_PANELS-1:0] mask_q;
   logic [3:0]            wr_q;
   logic [3:0]            bank_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [ADDR_W-1:0]     next_addr;
   logic [DATA_W-1:0]     wdat_q;

   logic [7:0]            hdr_idx;
   logic [3:0]            hdr_cmd;
   logic                  hdr_bad;
   logic [NUM_PANELS-1:0] hdr_mask;
   logic                  beat_acc;
   logic                  write_done;

   assign hdr_idx = udp_source.data[31:24];
   assign hdr_cmd = udp_source.data[23:20];

   always_comb begin
      hdr_bad  = (udp_source.dst_port != UDP_PORT)
               || !(hdr_cmd inside {CMD_WRITE_PIX, CMD_SWAP, CMD_LED_TOGGLE})
               || ((hdr_idx != IDX_BROADCAST) && (32'(hdr_idx) >= NUM_PANELS));
      hdr_mask = (hdr_idx == IDX_BROADCAST) ? '1 : (NUM_PANELS'(1) << hdr_idx);
   end

   // NOTE: ready is gated by resetn so no beat is consumed while reset is held.
   assign udp_source.ready = resetn & ((state != S_WRITE) | ctrl.ready | ~(|en_q));
   assign beat_acc         = udp_source.valid & udp_source.ready;
   assign write_done       = (|en_q) & ctrl.ready;

   assign ctrl.en   = en_q;
   assign ctrl.wr   = wr_q;
   assign ctrl.addr = addr_q;
   assign ctrl.wdat = wdat_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= S_HDR;
         en_q       <= '0;
         mask_q     <= '0;
         wr_q       <= '0;
         bank_q     <= '0;
         addr_q     <= '0;
         next_addr  <= '0;
         wdat_q     <= '0;
         swap       <= '0;
         led_reg    <= 1'b0;
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         swap <= '0;
         if (write_done) en_q <= '0;

         case (state)
            S_HDR: begin
               if (beat_acc) begin
                  if (hdr_bad) begin
                     drop_count <= sat_inc(drop_count);
                     state      <= udp_source.last ? S_HDR : S_DRAIN;
                  end else if (hdr_cmd == CMD_SWAP) begin
                     swap      <= hdr_mask;
                     pkt_count <= sat_inc(pkt_count);
                     state     <= udp_source.last ? S_HDR : S_DRAIN;
                  end else if (hdr_cmd == CMD_LED_TOGGLE) begin
                     led_reg   <= ~led_reg;
                     pkt_count <= sat_inc(pkt_count);
                     state     <= udp_source.last ? S_HDR : S_DRAIN;
                  end else if (udp_source.last) begin
                     pkt_count <= sat_inc(pkt_count);
                  end else begin
                     mask_q    <= hdr_mask;
                     bank_q    <= udp_source.data[19:16];
                     next_addr <= udp_source.data[ADDR_W-1:0];
                     state     <= S_WRITE;
                  end
               end
            end

            S_WRITE: begin
               // A new beat overrides the completion clear, giving back-to-back writes.
               if (beat_acc) begin
                  en_q      <= mask_q;
                  wr_q      <= bank_q;
                  addr_q    <= next_addr;
                  wdat_q    <= udp_source.data[DATA_W-1:0];
                  next_addr <= next_addr + ADDR_W'(1);
                  if (udp_source.last) begin
                     pkt_count <= sat_inc(pkt_count);
                     state     <= S_HDR;
                  end
               end
            end

            S_DRAIN: begin
               if (beat_acc && udp_source.last) state <= S_HDR;
            end

            default: state <= S_HDR;
         endcase
      end
   end

endmodule
